// File: rtl/sram_sp_be_ctrl_pkg.sv
// Shared widths and arbiter-pointer encoding for the single-port byte-enable SRAM controller.
// The optional round-robin arbiter is enabled by defining SRAM_CTRL_RR_ARB_EN.
package sram_sp_be_ctrl_pkg;

    localparam int ADR_WD_DEF  = 5;
    localparam int DAT_WD_DEF  = 8;
    localparam int COL_WD_DEF  = 8;
    localparam int RSP_DEP_DEF = 4;
    localparam int COL_NUM     = DAT_WD_DEF / COL_WD_DEF;

    // Pointer names the channel that wins the next contested cycle.
    typedef enum logic {
        ARB_PTR_RD = 1'b0,
        ARB_PTR_WR = 1'b1
    } arb_ptr_e;

    function automatic int col_num(input int dat_wd, input int col_wd);
        return dat_wd / col_wd;
    endfunction

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Read-response FIFO: synchronous push/pop, occupancy count, data reads as zero when empty.
// Built the same regardless of SRAM_CTRL_RR_ARB_EN.
module sram_ctrl_rsp_fifo
    import sram_sp_be_ctrl_pkg::*;
#(
    parameter int DEP    = RSP_DEP_DEF,
    parameter int DAT_WD = DAT_WD_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DAT_WD-1:0]      push_dat,
    input  logic                   pop,
    output logic [DAT_WD-1:0]      pop_dat,
    output logic [$clog2(DEP):0]   cnt
);

    localparam int PTR_WD = $clog2(DEP);

    logic [DAT_WD-1:0] mem [DEP];
    logic [PTR_WD-1:0] wr_ptr;
    logic [PTR_WD-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign pop_dat = (cnt != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sram_sp_be_ctrl.sv
// Arbitrates write/read request channels onto one column-enable SRAM port with credit-limited read responses.
// Define SRAM_CTRL_RR_ARB_EN for round-robin arbitration; default is fixed read priority.
module sram_sp_be_ctrl
    import sram_sp_be_ctrl_pkg::*;
#(
    parameter int ADR_WD  = ADR_WD_DEF,
    parameter int DAT_WD  = DAT_WD_DEF,
    parameter int COL_WD  = COL_WD_DEF,
    parameter int RSP_DEP = RSP_DEP_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_req_val,
    output logic                                 wr_req_rdy,
    input  logic [ADR_WD-1:0]                    wr_req_adr,
    input  logic [col_num(DAT_WD, COL_WD)-1:0]   wr_req_msk,
    input  logic [DAT_WD-1:0]                    wr_req_dat,
    input  logic                                 rd_req_val,
    output logic                                 rd_req_rdy,
    input  logic [ADR_WD-1:0]                    rd_req_adr,
    output logic                                 rd_rsp_val,
    input  logic                                 rd_rsp_rdy,
    output logic [DAT_WD-1:0]                    rd_rsp_dat,
    output logic [ADR_WD-1:0]                    mem_adr,
    output logic [col_num(DAT_WD, COL_WD)-1:0]   mem_wr_ena,
    output logic [DAT_WD-1:0]                    mem_wr_dat,
    output logic                                 mem_rd_ena,
    input  logic [DAT_WD-1:0]                    mem_rd_dat
);

    localparam int CNT_WD = $clog2(RSP_DEP) + 2;

    logic                     s2_rd;
    logic [$clog2(RSP_DEP):0] fifo_cnt;
    logic [CNT_WD-1:0]        cnt_out;
    logic                     rsp_pop;
    logic                     rd_ok;
    logic                     rd_gnt;
    logic                     wr_gnt;

    // Outstanding reads: S1 (mem_rd_ena), S2 tag, and buffered responses.
    assign cnt_out = CNT_WD'(mem_rd_ena) + CNT_WD'(s2_rd) + CNT_WD'(fifo_cnt);
    assign rsp_pop = rd_rsp_val & rd_rsp_rdy;
    assign rd_ok   = (cnt_out - CNT_WD'(rsp_pop)) < CNT_WD'(RSP_DEP);

`ifdef SRAM_CTRL_RR_ARB_EN
    arb_ptr_e arb_ptr;
    arb_ptr_e arb_ptr_nxt;

    always_comb begin
        arb_ptr_nxt = arb_ptr;
        rd_req_rdy  = rd_ok & ~(wr_req_val & (arb_ptr == ARB_PTR_WR));
        wr_req_rdy  = ~(rd_req_val & rd_ok & (arb_ptr == ARB_PTR_RD));
        if (rd_req_val & wr_req_val & rd_ok) begin
            arb_ptr_nxt = (arb_ptr == ARB_PTR_RD) ? ARB_PTR_WR : ARB_PTR_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_ptr <= ARB_PTR_RD;
        end else begin
            arb_ptr <= arb_ptr_nxt;
        end
    end
`else
    always_comb begin
        rd_req_rdy = rd_ok;
        wr_req_rdy = ~(rd_req_val & rd_ok);
    end
`endif

    assign rd_gnt = rd_req_val & rd_req_rdy;
    assign wr_gnt = wr_req_val & wr_req_rdy;

    // mem_adr and mem_wr_dat hold across idle cycles; enables drop to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_adr    <= '0;
            mem_wr_ena <= '0;
            mem_wr_dat <= '0;
            mem_rd_ena <= 1'b0;
            s2_rd      <= 1'b0;
        end else begin
            mem_wr_ena <= wr_gnt ? wr_req_msk : '0;
            mem_rd_ena <= rd_gnt;
            s2_rd      <= mem_rd_ena;
            if (rd_gnt) begin
                mem_adr <= rd_req_adr;
            end else if (wr_gnt) begin
                mem_adr    <= wr_req_adr;
                mem_wr_dat <= wr_req_dat;
            end
        end
    end

    sram_ctrl_rsp_fifo #(
        .DEP    (RSP_DEP),
        .DAT_WD (DAT_WD)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s2_rd),
        .push_dat (mem_rd_dat),
        .pop      (rsp_pop),
        .pop_dat  (rd_rsp_dat),
        .cnt      (fifo_cnt)
    );

    assign rd_rsp_val = (fifo_cnt != '0);

endmodule
